// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM state encoding,
// the word-alignment mask and the default bus wait limit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HOLD    = 2'd2,
        DRAIN   = 2'd3
    } fetch_state_t;

    // Low pc bits that must be zero for a word-aligned fetch
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Cycles a read may wait for busReady before it is abandoned
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Bus wait counter for the instruction fetch block. Counts cycles while a
// read is outstanding and flags expiry on the last allowed cycle, so the FSM
// can leave on the same edge. Only instantiated when FETCH_TIMEOUT_EN is set.
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count wait cycles; clearing on state entry takes priority over counting
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is asserted during the final permitted wait cycle
    always_comb begin
        expired = enable && (count == LAST);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads one word per request from the CPU bus at the
// address presented on pc and holds it for the decoder until accepted.
// Optional feature: define FETCH_TIMEOUT_EN to abandon reads that wait
// TIMEOUT_CYCLES cycles without busReady and raise the sticky busError flag.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fetchStart,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] busAddress,
    output logic                  busReadRequest,
    input  logic                  busReady,
    input  logic [DATA_WIDTH-1:0] busDataIn,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instructionValid,
    input  logic                  instructionReady,
    output logic                  busy,
    output logic                  misaligned,
    output logic                  busError
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("instruction_fetch: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t state;
    fetch_state_t next_state;

    logic pc_aligned;
    logic fetch_taken;
    logic accept_fetch;
    logic reject_fetch;
    logic capture;
    logic timeout_hit;

    assign pc_aligned = ((pc[1:0] & ALIGN_MASK) == 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; busReady beats timeout, and flush beats any new fetch
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fetchStart && !flush && pc_aligned) begin
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                if (busReady) begin
                    next_state = flush ? IDLE : HOLD;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end else if (flush) begin
                    next_state = DRAIN;
                end
            end
            HOLD: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (instructionReady) begin
                    next_state = (fetchStart && pc_aligned) ? REQUEST : IDLE;
                end
            end
            DRAIN: begin
                if (busReady || timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output/control decode: when a fetch request is taken, when bus data is kept
    always_comb begin
        fetch_taken  = fetchStart && !flush &&
                       ((state == IDLE) || ((state == HOLD) && instructionReady));
        accept_fetch = fetch_taken && pc_aligned;
        reject_fetch = fetch_taken && !pc_aligned;
        capture      = (state == REQUEST) && busReady && !flush;
        busy         = (state != IDLE);
    end

    // Registered bus and decoder-side outputs, one cycle behind the decision
    always_ff @(posedge clk) begin
        if (!reset) begin
            busAddress       <= '0;
            instruction      <= '0;
            busReadRequest   <= 1'b0;
            instructionValid <= 1'b0;
            misaligned       <= 1'b0;
        end else begin
            if (accept_fetch) begin
                busAddress <= pc;
            end
            if (capture) begin
                instruction <= busDataIn;
            end
            busReadRequest   <= (next_state == REQUEST) || (next_state == DRAIN);
            instructionValid <= (next_state == HOLD);
            if (accept_fetch) begin
                misaligned <= 1'b0;
            end else if (reject_fetch) begin
                misaligned <= 1'b1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic timer_run;
    logic timer_clear;
    logic timer_expired;

    assign timer_run   = (state == REQUEST) || (state == DRAIN);
    assign timer_clear = ((next_state == REQUEST) && (state != REQUEST)) ||
                         ((next_state == DRAIN) && (state != DRAIN));
    assign timeout_hit = timer_expired && !busReady;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_run),
        .expired(timer_expired)
    );

    // Sticky timeout flag, cleared by the next accepted fetch
    always_ff @(posedge clk) begin
        if (!reset) begin
            busError <= 1'b0;
        end else if (accept_fetch) begin
            busError <= 1'b0;
        end else if (timeout_hit) begin
            busError <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign busError    = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Consumes the program counter value and performs one instruction read per request on the CPU memory bus.
- Holds the returned word for the decoder until the decoder accepts it.
- Sits between the program counter (address source) and the decode stage; it is the reading end of the PC address path.
- Supports flush on jump/branch so stale fetches are discarded.

Parameters:
ADDR_WIDTH, 32, width of pc and busAddress
DATA_WIDTH, 32, width of busDataIn and instruction
TIMEOUT_CYCLES, 255, bus wait limit (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clk
pc  input  ADDR_WIDTH  address to fetch, sampled with fetchStart
fetchStart  input  1  request a fetch at pc
flush  input  1  abort current fetch, discard any pending data
busAddress  output  ADDR_WIDTH  bus read address
busReadRequest  output  1  bus read strobe, held until busReady
busReady  input  1  busDataIn valid this cycle
busDataIn  input  DATA_WIDTH  bus read data
instruction  output  DATA_WIDTH  fetched word
instructionValid  output  1  instruction holds valid data
instructionReady  input  1  decoder accepts instruction
busy  output  1  high in any state other than IDLE
misaligned  output  1  sticky: last request had pc[1:0] != 0
busError  output  1  sticky timeout flag (FETCH_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state = IDLE.
  - busAddress, instruction, busReadRequest, instructionValid, misaligned, busError all 0.
  - Reset wins over every other input, including mid-transaction; the outstanding bus read is abandoned.
- States: IDLE, REQUEST, HOLD, DRAIN.
- IDLE:
  - fetchStart=1 with pc[1:0]==0: latch pc into busAddress, go to REQUEST. busReadRequest is high from the next cycle (1-cycle latency). Clear misaligned.
  - fetchStart=1 with pc[1:0]!=0: set misaligned, stay in IDLE, issue no bus request.
- REQUEST:
  - busReadRequest=1 and busAddress stable until busReady.
  - On busReady: latch busDataIn into instruction, drop busReadRequest, go to HOLD. instructionValid rises the cycle after busReady (1-cycle latency).
- HOLD:
  - instructionValid=1 and instruction stable until instructionReady.
  - instructionReady=1 and fetchStart=1 in the same cycle: back-to-back fetch. Latch the new pc and go to REQUEST; instructionValid falls.
  - instructionReady=1 and fetchStart=0: go to IDLE.
- fetchStart in REQUEST or DRAIN is ignored. No queueing.
- flush:
  - In REQUEST: go to DRAIN. busReadRequest stays high until busReady, then the data is discarded and the block goes to IDLE.
  - In HOLD: instructionValid drops next cycle; go to IDLE.
  - In IDLE: no effect.
  - In DRAIN: no effect.
  - flush dominates a simultaneous fetchStart; that fetchStart is dropped.
- Addresses are not incremented internally; the address is always taken from pc. busAddress wraps only because the program counter wraps.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With it defined:
  - A cycle counter runs in REQUEST and DRAIN and clears on entry to either state.
  - If the counter reaches TIMEOUT_CYCLES without busReady: set busError (sticky until reset or next accepted fetchStart), drop busReadRequest, go to IDLE.
- Without it: no counter logic; busError is constant 0; the block waits for busReady indefinitely.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding constants (IDLE=2'd0, REQUEST=2'd1, HOLD=2'd2, DRAIN=2'd3);
  - the alignment mask constant (2'b11);
  - the default TIMEOUT_CYCLES.
- One sub-module, fetch_timeout_counter, containing the counter, clear and expiry compare. It is instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset: drive reset=0 for 1 edge with busReady=1 and fetchStart=1 -> all outputs 0, busy=0.
- Basic fetch: pc=32'h00000010, fetchStart pulse; busReady with busDataIn=32'hDEADBEEF 3 cycles later -> busAddress=32'h10, busReadRequest high exactly until the busReady cycle, instruction=32'hDEADBEEF, instructionValid high the next cycle and held until instructionReady.
- Back-to-back: in HOLD assert instructionReady and fetchStart with pc=32'h14 -> busReadRequest rises next cycle with busAddress=32'h14; no idle cycle in between.
- Flush in flight: fetch pc=32'h20, assert flush in REQUEST, then busReady with 32'h12345678 -> instructionValid never rises, block returns to IDLE, busy=0.
- Misaligned: pc=32'h00000006 with fetchStart -> misaligned=1, busReadRequest stays 0; a later fetch at pc=32'h8 clears misaligned.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4): fetch with busReady held 0 -> busError=1 and busReadRequest=0 after 4 REQUEST cycles; without the macro busReadRequest stays high for 100 cycles.
